// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage HI/LO multiply/divide unit with a fixed-latency Busy window
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic           a_neg, b_neg, accept;
  logic [31:0]    mag_a, mag_b, dvs, uq, ur;
  logic [63:0]    smul, umul, pend_d;
  // Result of the requested operation; signed divide works on magnitudes, so the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0, and a zero
  // divisor re-latches the current HI/LO so completion leaves them untouched.
  always_comb begin
    smul   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    umul   = {32'b0, A} * {32'b0, B};
    a_neg  = (Op == 3'd2) & A[31];
    b_neg  = (Op == 3'd2) & B[31];
    mag_a  = a_neg ? -A : A;
    mag_b  = b_neg ? -B : B;
    dvs    = (B == 32'd0) ? 32'd1 : mag_b;
    uq     = mag_a / dvs;
    ur     = mag_a % dvs;
    pend_d = Op[1] ? ((B == 32'd0) ? {hi_q, lo_q}
                                   : {a_neg ? -ur : ur, (a_neg ^ b_neg) ? -uq : uq})
                   : (Op[0] ? umul : smul);
    accept = Start & ~Cancel & (state_q == IDLE);
  end
  // Accept in IDLE, count down the Busy window in RUN, commit pending result on the last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (state_q == IDLE) begin
      if (accept && !Op[2]) begin
        {pend_hi_q, pend_lo_q} <= pend_d;
        cnt_q   <= Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_q <= RUN;
      end else if (accept && Op == 3'd4) begin
        hi_q <= A;
      end else if (accept && Op == 3'd5) begin
        lo_q <= A;
      end
    end else if (cnt_q == CW'(1)) begin
      hi_q    <= pend_hi_q;
      lo_q    <= pend_lo_q;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end
  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench with a behavioural HI/LO model checked every cycle
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd7;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cancel = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;
  int          tests = 0;
  int          fails = 0;
  logic        chk_on = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_left = 0;
  int          n;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {HI,LO} an operation must produce, from plain integer arithmetic
  function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 3'd0) return 64'(sa * sb);
    if (op == 3'd1) return ua * ub;
    if (b == 32'd0) return cur;
    if (op == 3'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Reference model: result appears once the operation's latency has elapsed
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_res <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) {m_hi, m_lo} <= m_res;
    end else if (Start && !Cancel) begin
      if (Op <= 3'd3) begin
        m_res  <= calc(Op, A, B, {m_hi, m_lo});
        m_left <= (Op >= 3'd2) ? DC : MC;
      end else if (Op == 3'd4) m_hi <= A;
      else if (Op == 3'd5) m_lo <= A;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_busy", {31'b0, Busy}, {31'b0, m_left > 0});
      cmp("model_hi", HI, m_hi);
      cmp("model_lo", LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    Start = 1'b1; Op = op; A = a; B = b; Cancel = cancel;
    @(negedge clk);
    Start = 1'b0; Op = 3'd7; Cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 100) cmp("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    cmp("rst_busy", {31'b0, Busy}, 32'd0);
    cmp("rst_hi", HI, 32'd0);
    cmp("rst_lo", LO, 32'd0);
    issue(3'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle(n);
    cmp("mult_cycles", n, MC);
    cmp("mult_hi", HI, 32'hFFFFFFFF);
    cmp("mult_lo", LO, 32'hFFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    @(negedge clk);
    issue(3'd4, 32'hDEAD, 32'd0, 1'b0);
    wait_idle(n);
    cmp("multu_hi", HI, 32'h1);
    cmp("multu_lo", LO, 32'hFFFFFFFE);
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    cmp("div_cycles", n, DC);
    cmp("div_lo", LO, 32'hFFFFFFFD);
    cmp("div_hi", HI, 32'hFFFFFFFF);
    issue(3'd4, 32'h11, 32'd0, 1'b0);
    cmp("mthi_busy", {31'b0, Busy}, 32'd0);
    issue(3'd5, 32'h22, 32'd0, 1'b0);
    issue(3'd3, 32'h99, 32'd0, 1'b0);
    wait_idle(n);
    cmp("divz_cycles", n, DC);
    cmp("divz_hi", HI, 32'h11);
    cmp("divz_lo", LO, 32'h22);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    cmp("ovf_lo", LO, 32'h80000000);
    cmp("ovf_hi", HI, 32'h0);
    issue(3'd4, 32'h1234, 32'd0, 1'b0);
    cmp("mthi_hi", HI, 32'h1234);
    cmp("mthi_nobusy", {31'b0, Busy}, 32'd0);
    issue(3'd0, 32'd3, 32'd3, 1'b1);
    cmp("cancel_busy", {31'b0, Busy}, 32'd0);
    cmp("cancel_hi", HI, 32'h1234);
    cmp("cancel_lo", LO, 32'h80000000);
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    Cancel = 1'b1;
    wait_idle(n);
    Cancel = 1'b0;
    cmp("cancel_run_cycles", n, MC);
    cmp("cancel_run_hi", HI, 32'h0);
    cmp("cancel_run_lo", LO, 32'd12);
    issue(3'd0, 32'h10000, 32'h30000, 1'b0);
    wait_idle(n);
    issue(3'd5, 32'd5, 32'd0, 1'b0);
    cmp("b2b_lo", LO, 32'd5);
    cmp("b2b_hi", HI, 32'h3);
    cmp("b2b_busy", {31'b0, Busy}, 32'd0);
    issue(3'd1, 32'd7, 32'd9, 1'b0);
    @(negedge clk);
    cmp("pre_rst_busy", {31'b0, Busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    cmp("async_busy", {31'b0, Busy}, 32'd0);
    cmp("async_hi", HI, 32'd0);
    cmp("async_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp("post_rst_busy", {31'b0, Busy}, 32'd0);
    cmp("post_rst_hi", HI, 32'd0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
